// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// display modes, segment constants and the hex-to-segment table.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam int         SEG_DP_BIT = 7;

    typedef enum logic {
        MODE_HEX = 1'b0,
        MODE_RAW = 1'b1
    } disp_mode_e;

    // Common-anode, active-low pattern {dp,g,f,e,d,c,b,a} with the dp dark.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'h0: hex_to_seg = 8'hC0;
            4'h1: hex_to_seg = 8'hF9;
            4'h2: hex_to_seg = 8'hA4;
            4'h3: hex_to_seg = 8'hB0;
            4'h4: hex_to_seg = 8'h99;
            4'h5: hex_to_seg = 8'h92;
            4'h6: hex_to_seg = 8'h82;
            4'h7: hex_to_seg = 8'hF8;
            4'h8: hex_to_seg = 8'h80;
            4'h9: hex_to_seg = 8'h90;
            4'hA: hex_to_seg = 8'h88;
            4'hB: hex_to_seg = 8'h83;
            4'hC: hex_to_seg = 8'hC6;
            4'hD: hex_to_seg = 8'hA1;
            4'hE: hex_to_seg = 8'h86;
            default: hex_to_seg = 8'h8E;
        endcase
    endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex digit decoder: nibble plus decimal point plus blanking
// to an active-low segment byte.
module seg7_hex_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    // A blanked digit still carries its decimal point.
    always_comb begin
        seg = blank ? SEG_BLANK : hex_to_seg(nibble);
        if (dp) begin
            seg[SEG_DP_BIT] = 1'b0;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with tear-free frame
// updates, leading-zero blanking, PWM brightness and a ghost-blank cycle.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NDIG      = 8,
    parameter int SCAN_LOG2 = 15,
    parameter int PWM_BITS  = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [8*NDIG-1:0]   i_data,
    input  logic                i_mode,
    input  logic [NDIG-1:0]     i_dp,
    input  logic                i_blank_lz,
    input  logic [PWM_BITS-1:0] i_bright,
    input  logic                i_load,
    output logic [7:0]          o_seg,
    output logic [NDIG-1:0]     o_sel,
    output logic                o_frame
);

    localparam int               DIG_W    = $clog2(NDIG);
    localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(NDIG - 1);

    logic [SCAN_LOG2-1:0] cyc;
    logic [DIG_W-1:0]     dig;
    logic                 wrap;
    logic                 frame_end;

    logic [8*NDIG-1:0]    sh_data,  act_data;
    disp_mode_e           sh_mode,  act_mode;
    logic [NDIG-1:0]      sh_dp,    act_dp;
    logic                 sh_blz,   act_blz;
    logic                 pend;

    assign wrap      = &cyc;
    assign frame_end = wrap && (dig == LAST_DIG);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc     <= '0;
            dig     <= '0;
            o_frame <= 1'b0;
        end else begin
            cyc     <= cyc + 1'b1;
            o_frame <= frame_end;
            if (wrap) begin
                dig <= (dig == LAST_DIG) ? '0 : dig + 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignment is what makes a load coinciding with the
    // frame end hand the *previous* shadow to active while keeping pend set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_data  <= '0;
            sh_mode  <= MODE_HEX;
            sh_dp    <= '0;
            sh_blz   <= 1'b0;
            act_data <= '0;
            act_mode <= MODE_HEX;
            act_dp   <= '0;
            act_blz  <= 1'b0;
            pend     <= 1'b0;
        end else begin
            if (frame_end && pend) begin
                act_data <= sh_data;
                act_mode <= sh_mode;
                act_dp   <= sh_dp;
                act_blz  <= sh_blz;
            end
            if (i_load) begin
                sh_data <= i_data;
                sh_mode <= disp_mode_e'(i_mode);
                sh_dp   <= i_dp;
                sh_blz  <= i_blank_lz;
                pend    <= 1'b1;
            end else if (frame_end) begin
                pend    <= 1'b0;
            end
        end
    end

    // Digit k>0 blanks when it and every more-significant nibble are zero.
    logic [NDIG-1:0] lz_mask;
    logic            upper_zero;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int k = NDIG - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (act_data[4*k +: 4] == 4'h0);
            lz_mask[k] = act_blz && upper_zero;
        end
    end

    logic [3:0] cur_nib;
    logic [7:0] cur_byte;
    logic       cur_dp;
    logic       cur_blank;
    logic [7:0] hex_seg;

    always_comb begin
        cur_nib   = '0;
        cur_byte  = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (dig == DIG_W'(k)) begin
                cur_nib   = act_data[4*k +: 4];
                cur_byte  = act_data[8*k +: 8];
                cur_dp    = act_dp[k];
                cur_blank = lz_mask[k];
            end
        end
    end

    seg7_hex_dec u_hex_dec (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .blank  (cur_blank),
        .seg    (hex_seg)
    );

    // Cycle 0 of each slot is the ghost-blank gap; the slot's top bits set PWM phase.
    logic [PWM_BITS-1:0] phase;
    logic                sel_on;
    logic [7:0]          seg_next;
    logic [NDIG-1:0]     sel_next;

    assign phase    = cyc[SCAN_LOG2-1 -: PWM_BITS];
    assign sel_on   = (cyc != '0) && ((&i_bright) || (phase < i_bright));
    assign seg_next = (act_mode == MODE_RAW) ? cur_byte : hex_seg;
    assign sel_next = sel_on ? ~(NDIG'(1) << dig) : '1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_seg <= SEG_BLANK;
            o_sel <= '1;
        end else begin
            o_seg <= seg_next;
            o_sel <= sel_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: stimulus queues expected frames, a
// negedge monitor rebuilds each displayed frame and compares at o_frame.
module tb_seg7_scan_ctrl;

    localparam int NDIG      = 4;
    localparam int SCAN_LOG2 = 4;
    localparam int PWM_BITS  = 2;
    localparam int SLOT      = 1 << SCAN_LOG2;
    localparam int FRAME     = NDIG * SLOT;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic [8*NDIG-1:0]   i_data;
    logic                i_mode;
    logic [NDIG-1:0]     i_dp;
    logic                i_blank_lz;
    logic [PWM_BITS-1:0] i_bright;
    logic                i_load;
    logic [7:0]          o_seg;
    logic [NDIG-1:0]     o_sel;
    logic                o_frame;

    seg7_scan_ctrl #(
        .NDIG      (NDIG),
        .SCAN_LOG2 (SCAN_LOG2),
        .PWM_BITS  (PWM_BITS)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_data     (i_data),
        .i_mode     (i_mode),
        .i_dp       (i_dp),
        .i_blank_lz (i_blank_lz),
        .i_bright   (i_bright),
        .i_load     (i_load),
        .o_seg      (o_seg),
        .o_sel      (o_sel),
        .o_frame    (o_frame)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          tag;
        logic [31:0] segs;
        bit          lit;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor state: sample index within the frame and the digits seen so far.
    int          frame_cnt = 0;
    int          pos = 0;
    bit          in_reset = 1'b0;
    logic [7:0]  cap_seg [NDIG];
    logic [3:0]  seen;
    bit          torn;
    int          sel_err;
    logic [1:0]  prev_bright;
    int          s_idx, s_cyc, s_dig, low_dig;
    logic [3:0]  exp_sel;

    task automatic clear_capture();
        for (int d = 0; d < NDIG; d++) cap_seg[d] = 8'hxx;
        seen    = '0;
        torn    = 1'b0;
        sel_err = 0;
        pos     = 0;
    endtask

    task automatic close_frame();
        exp_t e;
        check("frame_period", pos, FRAME);
        check("sel_pattern_errors", sel_err, 0);
        check("no_tear", torn, 0);
        while (exp_q.size() > 0 && exp_q[0].tag < frame_cnt) begin
            check("missed_frame_tag", exp_q[0].tag, frame_cnt);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].tag == frame_cnt) begin
            e = exp_q.pop_front();
            check("digits_lit", seen, e.lit ? 4'hF : 4'h0);
            if (e.lit) check("frame_segs", {cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0]}, e.segs);
        end
        frame_cnt++;
        clear_capture();
    endtask

    // Sample p of a frame reflects scan state p-1 (outputs are registered).
    always @(negedge clk) begin
        if (!rstn) begin
            if (!in_reset) begin
                in_reset = 1'b1;
                frame_cnt++;
            end
            clear_capture();
        end else begin
            in_reset = 1'b0;
            pos++;
            s_idx   = (pos - 1) % FRAME;
            s_cyc   = s_idx % SLOT;
            s_dig   = s_idx / SLOT;
            exp_sel = 4'hF;
            if (s_cyc != 0 && (prev_bright == 2'd3 || (s_cyc / (SLOT / 4)) < int'(prev_bright)))
                exp_sel[s_dig] = 1'b0;
            if (o_sel !== exp_sel) sel_err++;
            case (o_sel)
                4'hE:    low_dig = 0;
                4'hD:    low_dig = 1;
                4'hB:    low_dig = 2;
                4'h7:    low_dig = 3;
                default: low_dig = -1;
            endcase
            if (low_dig >= 0) begin
                if (!seen[low_dig]) begin
                    seen[low_dig]    = 1'b1;
                    cap_seg[low_dig] = o_seg;
                end else if (cap_seg[low_dig] !== o_seg) begin
                    torn = 1'b1;
                end
            end
            if (pos == FRAME + 1) check("frame_timeout", pos, FRAME);
            if (o_frame === 1'b1) close_frame();
        end
        prev_bright = i_bright;
    end

    task automatic push_exp(input int tag, input logic [31:0] segs, input bit lit);
        exp_t e;
        e.tag  = tag;
        e.segs = segs;
        e.lit  = lit;
        exp_q.push_back(e);
    endtask

    task automatic do_load(input logic [31:0] d, input logic m, input logic [3:0] dp, input logic blz);
        i_data     = d;
        i_mode     = m;
        i_dp       = dp;
        i_blank_lz = blz;
        i_load     = 1'b1;
        @(posedge clk);
        #1;
        i_load     = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_frame !== 1'b1 && n < 3 * FRAME);
        check("wait_frame", o_frame, 1'b1);
    endtask

    // Load at the start of the next frame; it must appear one frame later.
    task automatic step(input logic [31:0] d, input logic m, input logic [3:0] dp,
                        input logic blz, input logic [31:0] segs);
        int tag;
        wait_frame();
        @(posedge clk);
        #1;
        tag = frame_cnt;
        do_load(d, m, dp, blz);
        push_exp(tag + 1, segs, 1'b1);
    endtask

    int tag;

    initial begin
        i_data     = '0;
        i_mode     = 1'b0;
        i_dp       = '0;
        i_blank_lz = 1'b0;
        i_bright   = 2'd3;
        i_load     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_seg", o_seg, 8'hFF);
        check("reset_sel", o_sel, 4'hF);
        check("reset_frame", o_frame, 1'b0);
        @(negedge clk);
        #2 rstn = 1'b1;

        // Hex digits, full brightness; frame 0 still shows the reset zeros.
        @(posedge clk);
        #1;
        tag = frame_cnt;
        do_load(32'h0000_1234, 1'b0, 4'b0000, 1'b0);
        push_exp(tag, 32'hC0C0C0C0, 1'b1);
        push_exp(tag + 1, 32'hF9A4B099, 1'b1);

        // Leading-zero blanking and decimal points.
        step(32'h0000_0070, 1'b0, 4'b1000, 1'b1, 32'h7FFFF8C0);
        step(32'h0000_0000, 1'b0, 4'b0001, 1'b1, 32'hFFFFFF40);
        step(32'h0000_0000, 1'b0, 4'b0000, 1'b1, 32'hFFFFFFC0);

        // Raw mode ignores dp and blanking.
        step(32'h0062_0800, 1'b1, 4'b1111, 1'b1, 32'h00620800);

        // Two loads mid-frame at digit 1: only the second may ever be shown.
        wait_frame();
        @(posedge clk);
        #1;
        tag = frame_cnt;
        repeat (20) @(posedge clk);
        #1;
        do_load(32'h0000_AAAA, 1'b0, 4'b0000, 1'b0);
        do_load(32'h0000_BBBB, 1'b0, 4'b0000, 1'b0);
        push_exp(tag + 1, 32'h83838383, 1'b1);

        // Load mid-frame, then again exactly on the frame-end edge.
        wait_frame();
        @(posedge clk);
        #1;
        tag = frame_cnt;
        do_load(32'h0000_5555, 1'b0, 4'b0000, 1'b0);
        repeat (FRAME - 3) @(posedge clk);
        #1;
        do_load(32'h0000_6666, 1'b0, 4'b0000, 1'b0);
        push_exp(tag + 1, 32'h92929292, 1'b1);
        push_exp(tag + 2, 32'h82828282, 1'b1);
        wait_frame();
        wait_frame();

        // Brightness 1 for this frame, then a dark frame.
        @(posedge clk);
        #1;
        i_bright = 2'd1;
        wait_frame();
        @(posedge clk);
        #1;
        i_bright = 2'd0;
        push_exp(frame_cnt, 32'h82828282, 1'b0);
        wait_frame();
        @(posedge clk);
        #1;
        i_bright = 2'd3;

        // Reset mid-slot on digit 2 with an update pending.
        do_load(32'h0000_9999, 1'b0, 4'b0000, 1'b0);
        repeat (2 * SLOT + 3) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("midreset_seg", o_seg, 8'hFF);
        check("midreset_sel", o_sel, 4'hF);
        check("midreset_frame", o_frame, 1'b0);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
        tag = frame_cnt;
        push_exp(tag, 32'hC0C0C0C0, 1'b1);
        push_exp(tag + 1, 32'hC0C0C0C0, 1'b1);
        wait_frame();
        wait_frame();

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        checks++;
        failures++;
        $display("FAIL watchdog: simulation did not complete by t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
